// File: rtl/vote_session_ctrl.sv
// Session sequencer for the five-voter majority experiment. It opens a timed
// voting window, latches sticky per-voter "yes" flags, and tallies them when
// the window times out or all voters are in. It then presents count/pass for
// a fixed hold period.

// One voter's sticky yes flag. The flag clears when a session opens and sets
// on any sampled vote while the window is open. It never retracts.
module vote_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic v,
  output logic q
);
  // Sticky set and session clear. The clear wins so a restart starts clean.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= 1'b0;
    else if (en && v) q <= 1'b1;
  end
endmodule

module vote_session_ctrl #(
  parameter int WINDOW = 100,
  parameter int HOLD   = 50,
  parameter int THRESH = 3,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    vote,
  output logic          busy,
  output logic          voting,
  output logic [4:0]    latched,
  output logic [CW-1:0] remaining,
  output logic [2:0]    count,
  output logic          pass,
  output logic          done
);
  localparam int NUM_LANES = 5;
  localparam logic [CW-1:0] WIN_LD  = CW'(WINDOW);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD);

  typedef enum logic [1:0] {IDLE, VOTING, TALLY, RESULT} state_t;
  state_t state;

  logic                 open_sess;
  logic                 lat_en;
  logic [NUM_LANES-1:0] merged;
  logic                 all_in;
  logic                 cnt_last;
  logic [2:0]           pop;

  // Session-level control terms shared by the lanes and the FSM. merged
  // includes this cycle's votes, so a full house closes the window on the
  // same edge that latches the fifth flag.
  always_comb begin
    open_sess = start && ((state == IDLE) || (state == RESULT));
    lat_en    = (state == VOTING);
    merged    = latched | vote;
    all_in    = &merged;
    cnt_last  = (remaining == CW'(1));
  end

  // Popcount of the latched flags. It is only sampled in TALLY, where the
  // flags are frozen.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + 3'(latched[i]);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      vote_lane u_lane (
        .clk (clk),
        .rst (rst),
        .clr (open_sess),
        .en  (lat_en),
        .v   (vote[g]),
        .q   (latched[g])
      );
    end
  endgenerate

  // Main sequencer. All outputs except latched are registered here.
  // A restart from RESULT is checked before hold expiry so it takes
  // priority. remaining is nonzero only in VOTING/TALLY/RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      count     <= '0;
      pass      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      voting    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= VOTING;
            remaining <= WIN_LD;
            count     <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            voting    <= 1'b1;
          end
        end
        VOTING: begin
          remaining <= remaining - CW'(1);
          if (cnt_last || all_in) begin
            state  <= TALLY;
            voting <= 1'b0;
          end
        end
        TALLY: begin
          state     <= RESULT;
          count     <= pop;
          pass      <= (int'(pop) >= THRESH);
          done      <= 1'b1;
          remaining <= HOLD_LD;
        end
        RESULT: begin
          if (start) begin
            state     <= VOTING;
            remaining <= WIN_LD;
            count     <= '0;
            pass      <= 1'b0;
            voting    <= 1'b1;
          end else if (cnt_last) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
          end else begin
            remaining <= remaining - CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          busy      <= 1'b0;
          voting    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl. Each session is planned up front as a list of
// per-window-cycle vote vectors. The expected close cycle, tally and
// per-cycle output timeline are derived from the session timing rules with
// plain arithmetic relative to the start edge.
module tb_vote_session_ctrl;
  localparam int W  = 10;
  localparam int H  = 4;
  localparam int TH = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    vote;
  logic          busy, voting, pass, done;
  logic [4:0]    latched;
  logic [CW-1:0] remaining;
  logic [2:0]    count;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] held_lat;
  logic [2:0] held_cnt;
  logic       held_pass;

  logic [W:1][4:0] p;

  always #5 clk = ~clk;

  vote_session_ctrl #(.WINDOW(W), .HOLD(H), .THRESH(TH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vote      (vote),
    .busy      (busy),
    .voting    (voting),
    .latched   (latched),
    .remaining (remaining),
    .count     (count),
    .pass      (pass),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One idle cycle: start driven as given, random votes that must be ignored.
  // The previous session's result stays visible.
  task automatic idle_cycle(input bit s);
    @(posedge clk); #1;
    start = s;
    vote  = 5'($urandom);
    @(negedge clk);
    chk("idle_busy", 8'(busy), 8'd0);
    chk("idle_voting", 8'(voting), 8'd0);
    chk("idle_remaining", 8'(remaining), 8'd0);
    chk("idle_done", 8'(done), 8'd0);
    chk("idle_latched", 8'(latched), 8'(held_lat));
    chk("idle_count", 8'(count), 8'(held_cnt));
    chk("idle_pass", 8'(pass), 8'(held_pass));
  endtask

  // Runs one session. The caller has start=1 pending for the next edge.
  // Cycle t is the t-th cycle after that edge. restart_r > 0 asserts start in
  // result cycle restart_r and returns with start still pending.
  task automatic session(input logic [W:1][4:0] plan, input bit rnd,
                         input int restart_r, input bit rnd_start);
    logic [4:0] vq [1:W];
    logic [4:0] acc, lat;
    int c, last, ones;
    bit pass_e;
    for (int t = 1; t <= W; t++)
      vq[t] = rnd ? 5'($urandom & $urandom & $urandom) : plan[t];
    c = 0;
    acc = '0;
    for (int t = 1; t <= W; t++)
      if (c == 0) begin
        acc |= vq[t];
        if (acc == 5'h1f) c = t;
      end
    if (c == 0) c = W;
    ones   = $countones(acc);
    pass_e = (ones >= TH);
    last   = (restart_r > 0) ? c + 1 + restart_r : c + H + 2;
    @(posedge clk); #1;
    for (int t = 1; t <= last; t++) begin
      if (t > 1) begin @(posedge clk); #1; end
      vote = (t <= c) ? vq[t] : (rnd ? 5'($urandom) : 5'h1f);
      if (t <= c + 1) start = rnd_start && (t % 2 == 1);
      else            start = (restart_r > 0) && (t == last);
      @(negedge clk);
      lat = '0;
      for (int i = 1; i < t && i <= c; i++) lat |= vq[i];
      chk("latched", 8'(latched), 8'(lat));
      chk("voting", 8'(voting), 8'(t <= c));
      chk("busy", 8'(busy), 8'(t <= c + H + 1));
      chk("done", 8'(done), 8'(t == c + 2));
      chk("count", 8'(count), (t >= c + 2) ? 8'(ones) : 8'd0);
      chk("pass", 8'(pass), 8'((t >= c + 2) && pass_e));
      if (t != c + 1)
        chk("remaining", 8'(remaining),
            (t <= c) ? 8'(W - t + 1) : ((t <= c + H + 1) ? 8'(H - (t - c - 2)) : 8'd0));
    end
    if (restart_r == 0) begin
      held_lat  = acc;
      held_cnt  = 3'(ones);
      held_pass = pass_e;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vote = '0;
    held_lat = '0; held_cnt = '0; held_pass = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_voting", 8'(voting), 8'd0);
    chk("rst_latched", 8'(latched), 8'd0);
    chk("rst_remaining", 8'(remaining), 8'd0);
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_pass", 8'(pass), 8'd0);
    chk("rst_done", 8'(done), 8'd0);

    // Reset mid-VOTING with flags 00101 latched.
    idle_cycle(1'b1);
    @(posedge clk); #1; start = 1'b0; vote = 5'b00101;
    @(posedge clk); #1; vote = '0;
    @(negedge clk);
    chk("mid_latched", 8'(latched), 8'h05);
    chk("mid_voting", 8'(voting), 8'd1);
    rst = 1'b1; vote = 5'h1f;
    @(posedge clk); #1; rst = 1'b0; vote = '0;
    @(negedge clk);
    chk("mrst_busy", 8'(busy), 8'd0);
    chk("mrst_voting", 8'(voting), 8'd0);
    chk("mrst_latched", 8'(latched), 8'd0);
    chk("mrst_remaining", 8'(remaining), 8'd0);
    chk("mrst_done", 8'(done), 8'd0);
    chk("mrst_count", 8'(count), 8'd0);
    idle_cycle(1'b0);

    // Majority pass: 01011 pulsed in cycles 2, 5, 9.
    p = '0; p[2] = 5'b01011; p[5] = 5'b01011; p[9] = 5'b01011;
    idle_cycle(1'b1);
    session(p, 1'b0, 0, 1'b0);
    // Minority fail: voters 0 and 4 only; 11111 driven through RESULT.
    p = '0; p[3] = 5'b10001;
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    session(p, 1'b0, 0, 1'b0);
    // Early close: all five in cycle 3.
    p = '0; p[3] = 5'h1f;
    idle_cycle(1'b1);
    session(p, 1'b0, 0, 1'b0);
    // Last-cycle vote by voter 2, restart in the last RESULT cycle.
    p = '0; p[1] = 5'b00001; p[10] = 5'b00100;
    idle_cycle(1'b1);
    session(p, 1'b0, H, 1'b0);
    // Session entered by restart, with start toggling during the window.
    p = '0; p[4] = 5'b11010;
    session(p, 1'b0, 0, 1'b1);

    // Randomized sessions, gaps and restarts.
    idle_cycle(1'b1);
    for (int k = 0; k < 30; k++) begin
      int r;
      r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, H)) : 0;
      session('0, 1'b1, r, 1'($urandom_range(0, 1)));
      if (r == 0) begin
        repeat ($urandom_range(0, 3)) idle_cycle(1'b0);
        idle_cycle(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Session sequencer for the five-voter majority-vote experiment. Opens a timed voting window on a start pulse and latches each voter's "yes" press (sticky, no retraction). It closes the window on timeout or when all five have voted, tallies the latched votes, and presents count and pass/fail for a fixed hold period. The pass decision equals the 3-of-5 majority combinational voter when THRESH = 3; this block supplies the sequencing, latching and timing around it.

## Interface
- WINDOW, default 100: voting window length in cycles; legal range 1..2^CW-1.
- HOLD, default 50: RESULT hold length in cycles; legal range 1..2^CW-1.
- THRESH, default 3: minimum yes count for pass; legal range 1..5.
- CW, default 8: width of the countdown counter.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  session request, sampled each cycle.
- vote  input  5  per-voter yes level; bit i is voter i.
- busy  output  1  high in every state except IDLE.
- voting  output  1  high only in VOTING.
- latched  output  5  sticky yes flags for the current session.
- remaining  output  CW  cycles left in the current VOTING or RESULT phase.
- count  output  3  registered popcount of latched, valid from done onward.
- pass  output  1  registered (count >= THRESH).
- done  output  1  one-cycle pulse when the result becomes valid.

## Operation
- Reset (rst = 1 at an edge), from any state including mid-session:
  - state <- IDLE
  - latched, count, remaining <- 0
  - pass, done, busy, voting <- 0
- States: IDLE, VOTING, TALLY, RESULT.
- IDLE:
  - start = 1 -> VOTING.
  - On that edge: latched <- 0, count <- 0, pass <- 0, remaining <- WINDOW.
- VOTING:
  - Each cycle: latched <- latched | vote, and remaining decrements by 1.
  - Exit to TALLY when remaining == 1, or when (latched | vote) == 5'b11111 (early close).
  - start is ignored.
- TALLY (exactly 1 cycle):
  - count <- popcount(latched); pass <- (popcount >= THRESH); done <- 1 on the same edge.
  - remaining <- HOLD; next state RESULT.
- RESULT:
  - remaining decrements each cycle; latched, count and pass are held.
  - start = 1 -> VOTING, with the same clearing as from IDLE. This restart takes priority over the hold expiry.
  - Otherwise, remaining == 1 -> IDLE. count, pass and latched stay visible in IDLE until the next start.
- vote is ignored in IDLE, TALLY and RESULT.
- count arithmetic is 3-bit unsigned, maximum 5; no overflow is possible.
- remaining never wraps below 0. In IDLE it is 0.

## Timing
- Edge k samples start = 1 in IDLE. Then:
  - Cycles k+1 .. k+WINDOW are VOTING; voting = 1 and remaining shows WINDOW .. 1.
  - A vote present in the last VOTING cycle is counted.
- Without early close:
  - TALLY occupies cycle k+WINDOW+1.
  - done = 1 and count/pass are valid in cycle k+WINDOW+2, the first RESULT cycle.
  - RESULT lasts HOLD cycles; IDLE starts at cycle k+WINDOW+HOLD+2.
- Early close: if the fifth flag latches at the edge ending VOTING cycle j, TALLY is cycle j+1 and done is in cycle j+2.
- done is high for exactly 1 cycle per session. busy = 1 from k+1 through the last RESULT cycle.
- Votes are level-sampled. A voter held high for many cycles still contributes one vote. A vote pulse of one cycle is sufficient.
- Simultaneous events:
  - vote and the window expiry in the same cycle: the vote counts.
  - start and RESULT expiry in the same cycle: the restart wins.

## Test plan
- Reset mid-VOTING: assert rst with latched = 5'b00101 -> next cycle shows state IDLE, latched = 0, busy = 0, remaining = 0, done = 0.
- Majority pass, WINDOW=10, HOLD=4: start at cycle 0; vote = 5'b01011 pulsed one cycle each at cycles 2, 5, 9 -> latched = 5'b01011, done at cycle 12, count = 3, pass = 1, IDLE at cycle 16.
- Minority fail: only voters 0 and 4 vote -> count = 2, pass = 0. vote = 5'b11111 applied during RESULT -> latched unchanged.
- Early close: all five bits high at cycle 3 of the window -> TALLY at the following cycle; done two cycles after the close edge; count = 5, pass = 1; remaining never reaches 1 in VOTING.
- Last-cycle vote and restart:
  - Voter 2 votes only in the final VOTING cycle -> latched[2] = 1 and it is counted.
  - start asserted in the last RESULT cycle -> VOTING entered, latched cleared, count = 0, remaining = WINDOW.
- start ignored in VOTING: pulse start mid-window -> remaining continues decrementing; done occurs once, at the nominal cycle.
